// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, baud divisors at 25 MHz
// and frame geometry.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam int BAUD_115200    = 217;
  localparam int BAUD_9600      = 2604;
  localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO with show-ahead read data; the head entry is
// always visible on rdata while the FIFO is not empty.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == CW'(0));
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign rdata     = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage array: written on accepted pushes only, no reset needed.
  always_ff @(posedge i_clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a byte FIFO in front of a start/data/stop
// serialiser that chains queued frames with no idle gap.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CYCLES_PER_BIT = BAUD_115200,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [7:0]                  i_tx_byte,
  input  logic                        i_tx_valid,
  output logic                        o_tx_ready,
  output logic                        o_tx_serial,
  output logic                        o_tx_active,
  output logic                        o_tx_done,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);

  localparam int BW = $clog2(CYCLES_PER_BIT);

  tx_state_t state_r;
  logic [BW-1:0] baud_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;
  logic          serial_r;
  logic          active_r;
  logic          done_r;

  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  logic          baud_last_s;
  logic [7:0]    head_s;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (i_tx_valid),
    .pop     (pop_s),
    .wdata   (i_tx_byte),
    .rdata   (head_s),
    .count   (o_fifo_count),
    .full    (full_s),
    .empty   (empty_s)
  );

  assign baud_last_s = (baud_r == BW'(CYCLES_PER_BIT - 1));
  assign o_tx_ready  = ~full_s;
  assign o_tx_serial = serial_r;
  assign o_tx_active = active_r;
  assign o_tx_done   = done_r;

  // Pop the head when idle, or on the final stop cycle to chain the next frame.
  always_comb begin
    pop_s = 1'b0;
    if (empty_s) begin
      pop_s = 1'b0;
    end else if (state_r == ST_IDLE) begin
      pop_s = 1'b1;
    end else if ((state_r == ST_STOP) && baud_last_s) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Serialiser FSM; done is raised one cycle early so it is high during the final stop cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= ST_IDLE;
      baud_r    <= BW'(0);
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      serial_r  <= 1'b1;
      active_r  <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= (state_r == ST_STOP) && (baud_r == BW'(CYCLES_PER_BIT - 2));
      case (state_r)
        ST_IDLE: begin
          baud_r   <= BW'(0);
          serial_r <= 1'b1;
          if (pop_s) begin
            shift_r  <= head_s;
            serial_r <= 1'b0;
            active_r <= 1'b1;
            state_r  <= ST_START;
          end
        end
        ST_START: begin
          if (baud_last_s) begin
            baud_r    <= BW'(0);
            bit_idx_r <= 3'd0;
            serial_r  <= shift_r[0];
            state_r   <= ST_DATA;
          end else begin
            baud_r <= baud_r + BW'(1);
          end
        end
        ST_DATA: begin
          if (!baud_last_s) begin
            baud_r <= baud_r + BW'(1);
          end else if (bit_idx_r == 3'(UART_DATA_BITS - 1)) begin
            baud_r   <= BW'(0);
            serial_r <= 1'b1;
            state_r  <= ST_STOP;
          end else begin
            baud_r    <= BW'(0);
            shift_r   <= {1'b0, shift_r[7:1]};
            serial_r  <= shift_r[1];
            bit_idx_r <= bit_idx_r + 3'd1;
          end
        end
        ST_STOP: begin
          if (!baud_last_s) begin
            baud_r <= baud_r + BW'(1);
          end else if (pop_s) begin
            baud_r   <= BW'(0);
            shift_r  <= head_s;
            serial_r <= 1'b0;
            state_r  <= ST_START;
          end else begin
            baud_r   <= BW'(0);
            active_r <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        default: begin
          baud_r   <= BW'(0);
          serial_r <= 1'b1;
          active_r <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered UART transmitter: accepts bytes over a valid/ready handshake into an internal FIFO and serialises them as 8N1 frames, LSB first, on an idle-high line. It is the transmit end of the board's UART link, feeding `o_UART_TX` at the top level. It replaces ad-hoc one-byte holding registers in front of the transmitter, so producers such as loopback, debug dumps or command responses can burst several bytes without tracking transmitter state.

## Interface
- `CYCLES_PER_BIT`, default 217: clock cycles per bit (217 = 115200 baud @ 25 MHz; 2604 = 9600). Must be ≥ 2.
- `FIFO_DEPTH`, default 4: FIFO entries. Must be a power of two, ≥ 2.
- Clock is `i_clk`. Reset is `i_rst_n`, asynchronous, active-low. Both are fixed.
- `i_clk`  in  1  system clock
- `i_rst_n`  in  1  asynchronous active-low reset
- `i_tx_byte`  in  8  byte to send; sampled when `i_tx_valid & o_tx_ready`
- `i_tx_valid`  in  1  producer has a byte
- `o_tx_ready`  out  1  FIFO not full
- `o_tx_serial`  out  1  UART line, registered, idle high
- `o_tx_active`  out  1  a frame is on the line (START/DATA/STOP)
- `o_tx_done`  out  1  one-cycle pulse at the end of each stop bit
- `o_fifo_count`  out  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the byte being shifted

## Operation
- Push: on a clock edge with `i_tx_valid & o_tx_ready`, write `i_tx_byte` at the write pointer. If `o_tx_ready` is low, `i_tx_valid` is ignored and nothing is dropped silently into the FIFO; the producer holds.
- `o_tx_ready = (count != FIFO_DEPTH)`.
- Pointers wrap modulo `FIFO_DEPTH`. `count` is incremented on push, decremented on pop, and unchanged when both happen on the same edge.
- FIFO read data is show-ahead: the head entry is combinationally visible to the FSM.
- FSM states:
  - IDLE: line high. If count > 0, pop the head into the shift register, drive the line low, and go to START.
  - START: hold 0 for `CYCLES_PER_BIT` cycles, then drive bit 0 and go to DATA with bit index 0.
  - DATA: hold `shift[0]` for `CYCLES_PER_BIT` cycles, then shift right and increment the index. After index 7 completes, drive 1 and go to STOP.
  - STOP: hold 1 for `CYCLES_PER_BIT` cycles. On the final cycle, pulse `o_tx_done`. If count > 0, pop, drive the line low and go to START with no idle gap; otherwise go to IDLE.
- Baud counter runs from 0 to `CYCLES_PER_BIT-1` and is reset to 0 on every state or bit transition.
- Reset values: `o_tx_serial` = 1, `o_tx_active` = 0, `o_tx_done` = 0, `o_tx_ready` = 1, `o_fifo_count` = 0, FSM = IDLE, pointers = 0.
- Reset asserted mid-frame: the line returns high immediately (asynchronous), the FIFO is flushed, and the partial frame is abandoned.

## Timing
- Latency: a byte pushed at edge N into an empty FIFO, with FSM in IDLE, is popped at edge N+1. `o_tx_serial` falls after N+1.
- Frame length is exactly `10*CYCLES_PER_BIT` cycles from the start-bit falling edge to the next possible start bit.
- Back-to-back frames are gapless. The next start bit begins the cycle after the `o_tx_done` pulse cycle's edge.
- `o_tx_active` is high from the edge entering START through the last STOP cycle. It stays high across back-to-back frames.
- Push and pop on the same edge with count == FIFO_DEPTH is impossible because ready is low. When count == 0, a push and the FSM's IDLE check on the same edge do not pop the new byte until the next edge.
- `o_tx_done` and `o_tx_active` are registered. No combinational path exists from inputs to outputs except `i_tx_valid` → none. `o_tx_ready` derives from registered count only.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (IDLE, START, DATA, STOP)
  - `BAUD_115200` = 217 and `BAUD_9600` = 2604 at 25 MHz
  - `UART_DATA_BITS` = 8
- Sub-module `byte_fifo`: synchronous, show-ahead FIFO with parameter DEPTH. Ports are push, pop, wdata, rdata, count, full and empty; reset is asynchronous active-low.
- Top of block: `byte_fifo` plus the FSM, baud counter, bit index and shift register.

## Test plan
- Single byte 0xA5, `CYCLES_PER_BIT`=4: line is low 4 cycles, then 1,0,1,0,0,1,0,1, each 4 cycles, then high 4 cycles. `o_tx_done` pulses once at cycle 40 after the start; `o_tx_active` is high for exactly 40 cycles.
- Burst 0x01, 0x02, 0x03, 0x04 pushed on consecutive cycles, DEPTH=4: all accepted and `o_fifo_count` peaks at 3 (first byte popped). Four gapless frames follow (160 cycles at CPB=4), with 4 done pulses and the decoded bytes in order.
- Overflow: hold valid with six bytes 0x10–0x15, DEPTH=4. Ready drops after 5 acceptances (4 queued + 1 in shifter). 0x15 is accepted only after the first pop, and all six bytes are transmitted in order.
- Pointer wrap: send 10 bytes 0x30–0x39 with random valid gaps. Received sequence matches, and count returns to 0.
- Reset mid-frame: assert `i_rst_n`=0 during DATA bit 3 of 0xFF with 2 bytes queued. Line is high immediately, count=0 and ready=1; after release, the line stays idle with no further frames.
- Push on the same edge as a STOP-final pop with count=1: count stays 1, and the next frame starts without a gap.
